// File: rtl/clk_ratio_meter.sv
// Measures a slow clock against i_ref_clk: period, high-phase length, lock and error flags.
// The slow clock is synchronized with two flops; a third flop supplies the rising-edge detect.
module clk_ratio_meter #(
    parameter int RATIO_WD = 4,
    parameter int LOCK_CNT = 3
) (
    input  logic                i_ref_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_slow_clk,
    output logic [RATIO_WD-1:0] o_ratio,
    output logic [RATIO_WD-1:0] o_high,
    output logic                o_valid,
    output logic                o_locked,
    output logic                o_err
);

    localparam logic [RATIO_WD-1:0] PER_MAX  = '1;
    localparam logic [3:0]          LOCK_TOP = 4'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, SEEK, MEASURE} state_t;

    state_t              state, state_nxt;
    logic                s1, s2, s3;
    logic                rise;
    logic [RATIO_WD-1:0] per, hi;
    logic [3:0]          lock_run, lock_nxt;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_slow_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = SEEK;
            SEEK:    if (rise) state_nxt = MEASURE;
            MEASURE: if (!rise && per == PER_MAX) state_nxt = SEEK;
            default: state_nxt = IDLE;
        endcase
        if (!i_en) state_nxt = IDLE;
    end

    // lock_run==0 marks the first measurement after an edge search
    always_comb begin
        lock_nxt = 4'd1;
        if (lock_run != 4'd0 && per == o_ratio)
            lock_nxt = (lock_run >= LOCK_TOP) ? LOCK_TOP : lock_run + 4'd1;
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            per      <= '0;
            hi       <= '0;
            lock_run <= '0;
            o_ratio  <= '0;
            o_high   <= '0;
            o_valid  <= 1'b0;
            o_locked <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (!i_en || state == IDLE) begin
                per      <= '0;
                hi       <= '0;
                lock_run <= '0;
                o_locked <= 1'b0;
                o_err    <= 1'b0;
            end else if (state == SEEK) begin
                if (rise) begin
                    per      <= RATIO_WD'(1);
                    hi       <= RATIO_WD'(1);
                    lock_run <= '0;
                    o_err    <= 1'b0;
                end
            end else if (rise) begin
                o_ratio  <= per;
                o_high   <= hi;
                o_valid  <= 1'b1;
                per      <= RATIO_WD'(1);
                hi       <= RATIO_WD'(1);
                lock_run <= lock_nxt;
                o_locked <= (lock_nxt == LOCK_TOP);
            end else if (per == PER_MAX) begin
                // period overflow or lost clock: drop lock and search again
                o_err    <= 1'b1;
                o_locked <= 1'b0;
                lock_run <= '0;
            end else begin
                per <= per + RATIO_WD'(1);
                if (s2) hi <= hi + RATIO_WD'(1);
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: drives slow-clock bursts, predicts reports into a queue.
module tb_clk_ratio_meter;

    localparam int LOCK = 3;

    typedef struct packed {
        logic [3:0] ratio;
        logic [3:0] high;
        logic       locked;
    } exp_t;

    logic       i_ref_clk = 1'b0;
    logic       i_rst_n   = 1'b0;
    logic       i_en      = 1'b0;
    logic       i_slow_clk = 1'b0;
    logic [3:0] o_ratio, o_high;
    logic       o_valid, o_locked, o_err;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model state: whether the next rise closes a reportable period
    bit   have_prev = 0;
    int   prev_n = 0, prev_h = 0;
    int   m_lock = 0, m_rep = 0;

    clk_ratio_meter #(.RATIO_WD(4), .LOCK_CNT(LOCK)) dut (
        .i_ref_clk (i_ref_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_slow_clk(i_slow_clk),
        .o_ratio   (o_ratio),
        .o_high    (o_high),
        .o_valid   (o_valid),
        .o_locked  (o_locked),
        .o_err     (o_err)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_ref_clk);
    endtask

    task automatic seek_model();
        have_prev = 0;
        m_lock    = 0;
    endtask

    // n periods of length per_n, high for per_h ref cycles, starting with a rise
    task automatic drive(input int per_n, input int per_h, input int n);
        for (int k = 0; k < n; k++) begin
            if (have_prev) begin
                if (m_lock == 0)          m_lock = 1;
                else if (prev_n == m_rep) m_lock = (m_lock >= LOCK) ? LOCK : m_lock + 1;
                else                      m_lock = 1;
                m_rep = prev_n;
                sb.push_back(exp_t'{4'(prev_n), 4'(prev_h), (m_lock == LOCK)});
            end
            have_prev = 1;
            prev_n = per_n;
            prev_h = per_h;
            if (per_n > 15) seek_model();
            i_slow_clk = 1'b1;
            tick(per_h);
            i_slow_clk = 1'b0;
            tick(per_n - per_h);
        end
    endtask

    always @(negedge i_ref_clk) begin
        if (i_rst_n && o_valid) begin
            n_chk++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_valid: o_valid=1 ratio=%0d, expected no report", o_ratio);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("ratio",  int'(o_ratio),  int'(e.ratio));
                chk("high",   int'(o_high),   int'(e.high));
                chk("locked", int'(o_locked), int'(e.locked));
                chk("err_on_valid", int'(o_err), 0);
            end
        end
    end

    initial begin
        tick(2);
        chk("rst_ratio",  int'(o_ratio),  0);
        chk("rst_high",   int'(o_high),   0);
        chk("rst_valid",  int'(o_valid),  0);
        chk("rst_locked", int'(o_locked), 0);
        chk("rst_err",    int'(o_err),    0);
        i_rst_n = 1'b1;
        i_en    = 1'b1;
        tick(2);

        drive(8, 4, 5);
        chk("lock_8", int'(o_locked), 1);
        chk("err_8",  int'(o_err),    0);
        drive(5, 3, 5);
        drive(6, 3, 5);
        chk("lock_6", int'(o_locked), 1);

        // slow clock stops low
        tick(20);
        seek_model();
        chk("lost_err",    int'(o_err),    1);
        chk("lost_locked", int'(o_locked), 0);
        drive(4, 2, 4);
        chk("restart_err", int'(o_err), 0);

        drive(15, 7, 3);
        chk("max_err",   int'(o_err),   0);
        chk("max_ratio", int'(o_ratio), 15);
        drive(16, 8, 1);
        tick(4);
        chk("ovf_err",    int'(o_err),    1);
        chk("ovf_locked", int'(o_locked), 0);

        drive(8, 4, 5);
        chk("pre_dis_lock", int'(o_locked), 1);
        tick(2);
        i_en = 1'b0;
        tick(1);
        chk("dis_locked", int'(o_locked), 0);
        chk("dis_valid",  int'(o_valid),  0);
        tick(3);
        chk("dis_ratio_kept", int'(o_ratio), 8);
        i_en = 1'b1;
        seek_model();
        tick(2);
        drive(7, 2, 3);

        // asynchronous reset away from any clock edge
        tick(2);
        #3 i_rst_n = 1'b0;
        #1;
        chk("arst_ratio",  int'(o_ratio),  0);
        chk("arst_high",   int'(o_high),   0);
        chk("arst_valid",  int'(o_valid),  0);
        chk("arst_locked", int'(o_locked), 0);
        chk("arst_err",    int'(o_err),    0);
        sb.delete();
        seek_model();
        @(negedge i_ref_clk);
        i_rst_n = 1'b1;
        tick(2);
        drive(6, 2, 4);
        tick(6);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
- Measures an incoming slow clock in units of i_ref_clk cycles.
- Reports the period (the division ratio), the high-phase length, and a lock flag once the period has been stable for LOCK_CNT consecutive periods.
- Sits beside clock dividers to close the loop on divided clocks: it checks that a generated clock matches the ratio that was programmed.
- Also used to detect lost or out-of-range slow clocks.

Parameters:
- RATIO_WD, 4: width of period/high counters and outputs; max measurable period 2^RATIO_WD-1.
- LOCK_CNT, 3: consecutive identical period measurements required to assert o_locked (1..15).

Ports:
- i_ref_clk  input  1  reference clock; all logic on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  measurement enable; low forces IDLE.
- i_slow_clk  input  1  clock under measurement; asynchronous to i_ref_clk.
- o_ratio  output  RATIO_WD  last measured period in ref cycles.
- o_high  output  RATIO_WD  last measured high-phase length in ref cycles.
- o_valid  output  1  one-cycle pulse when o_ratio/o_high update.
- o_locked  output  1  period stable for LOCK_CNT consecutive measurements.
- o_err  output  1  sticky: period overflow or slow clock lost; cleared by a new first edge or by i_en low.

Behaviour:
- Reset values: all outputs 0; sync flops 0; state IDLE; counters 0.
- Input sync:
  - i_slow_clk passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = s2 & ~s3.
  - Measurement is therefore delayed 3 ref cycles from the pin; the delay does not affect the values.
- State IDLE:
  - Counters held at 0; o_locked=0, o_err=0, o_valid=0.
  - o_ratio/o_high keep their last values.
  - i_en=1 -> SEEK next cycle.
- State SEEK:
  - Waits for rise.
  - On rise: per=1, hi=1, o_err<=0, lock_run=0, go to MEASURE.
  - No counting before the first edge; a partial first period is never reported.
- State MEASURE, every cycle without rise:
  - per<=per+1.
  - hi<=hi+1 if s2=1, else hi holds.
- State MEASURE, rise cycle:
  - o_ratio<=per, o_high<=hi, o_valid<=1 for exactly that next cycle.
  - Then per<=1, hi<=1.
- Result: a slow clock with rising edges N ref cycles apart and high for H ref cycles reports o_ratio=N, o_high=H.
- Lock counting (evaluated on each rise in MEASURE):
  - If per equals the previously reported o_ratio: lock_run increments, saturating at LOCK_CNT. Otherwise lock_run=1.
  - o_locked=1 when lock_run==LOCK_CNT (updates with o_valid).
  - The first measurement after SEEK sets lock_run=1.
- Overflow:
  - If per reaches all-ones (2^RATIO_WD-1) and no rise occurs that cycle: o_err<=1, o_locked<=0, lock_run<=0, state<=SEEK.
  - o_ratio/o_high are not updated; no o_valid.
- Simultaneous events:
  - rise on the same cycle per==all-ones is a valid measurement of 2^RATIO_WD-1, not an error.
  - i_en=0 has priority over everything: next state IDLE, pending measurement discarded, no o_valid.
- Minimum measurable period is 2; a constant-high or constant-low slow clock produces overflow.
- Async reset mid-measurement returns immediately to reset values. The first o_valid after reset release needs the first edge (SEEK) plus one full period.
- Arithmetic: counters are unsigned RATIO_WD bits. per never wraps because overflow is caught at all-ones; hi <= per always holds.

Test Plan:
- Reset then i_en=1; slow clock period 8, high 4 -> first o_valid one period after the first edge with o_ratio=8, o_high=4. o_locked rises on the 3rd o_valid, o_err=0.
- Period 5, high 3 (odd ratio) -> o_ratio=5, o_high=3 each period; then switch to period 6, high 3 -> the next o_valid shows 6, o_locked drops that same update and re-asserts after 3 matching periods.
- Stop the slow clock low after lock (RATIO_WD=4) -> 15 ref cycles after the last rise: o_err=1, o_locked=0, no o_valid. Restart with period 4 -> o_err clears on the first rise, then o_ratio=4 after one period.
- Slow clock period exactly 15 -> valid measurement o_ratio=15, o_err stays 0. Period 16 -> o_err=1.
- Drop i_en mid-period -> next cycle IDLE, no o_valid, o_locked=0. Re-enable -> SEEK, and the first report comes one full period after the first edge.
- Assert i_rst_n=0 asynchronously mid-period -> all outputs 0 immediately. Release -> normal measurement resumes, with o_ratio correct from the second edge.
